fft_sequencer: RTL and testbench

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_sequencer.sv | 177 +++++++++++++++++
 tb/tb_fft_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sequencer.sv
// fft_sequencer: captures one audio frame, streams it into an fft core, and forwards the results.
// Define FFT_SEQ_OVERRUN_CNT_EN to count dropped samples on the overrun port.
module fft_sequencer #(
    parameter int width = 16,
    parameter int N_2   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               sample_valid,
    input  logic [width-1:0]   sample,
    output logic               fft_load,
    output logic [width-1:0]   fft_rd,
    output logic               fft_start,
    input  logic               fft_done,
    input  logic [2*width-1:0] fft_wd,
    output logic               out_valid,
    output logic [2*width-1:0] out_data,
    output logic [N_2-1:0]     out_idx,
    output logic               out_last,
    output logic               busy,
    output logic [7:0]         overrun
);

    localparam int N = 1 << N_2;
    localparam logic [N_2:0] C_LAST = {1'b0, {N_2{1'b1}}};

    typedef enum logic [2:0] {
        S_FILL,
        S_LOAD,
        S_START,
        S_WAIT,
        S_UNLOAD
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [width-1:0] r_buf [N];
    logic [N_2:0]     r_wptr;
    logic [N_2-1:0]   r_rptr;
    logic [N_2:0]     r_ucnt;

    logic w_write;
    logic w_fill_done;
    logic w_rlast;
    logic w_ulast;
    logic w_cap;
    logic w_to_fill;

    assign w_write     = (r_state == S_FILL) && run && sample_valid;
    assign w_fill_done = w_write && (r_wptr == C_LAST);
    assign w_rlast     = (r_rptr == '1);
    assign w_ulast     = (r_ucnt == C_LAST);

    // A run drop while waiting wins over a coinciding first result word.
    assign w_cap = fft_done &&
                   (((r_state == S_WAIT) && run) ||
                    (r_state == S_UNLOAD));

    assign w_to_fill = (r_state != S_FILL) && (w_next == S_FILL);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FILL: begin
                if (w_fill_done) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_rlast) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (fft_done) begin
                    w_next = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (!fft_done || w_ulast) begin
                    w_next = S_FILL;
                end
            end
            default: begin
                w_next = S_FILL;
            end
        endcase
        // An unload in progress always drains its frame first.
        if (!run && (r_state != S_UNLOAD)) begin
            w_next = S_FILL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_buf[r_wptr[N_2-1:0]] <= sample;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
        end else if (w_to_fill || !run) begin
            r_wptr <= '0;
        end else if (w_write) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rptr <= '0;
        end else if ((r_state == S_LOAD) && (w_next == S_LOAD)) begin
            r_rptr <= r_rptr + 1'b1;
        end else begin
            r_rptr <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ucnt    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            out_valid <= w_cap;
            out_last  <= w_cap && w_ulast;
            if (w_cap) begin
                r_ucnt   <= r_ucnt + 1'b1;
                out_data <= fft_wd;
                out_idx  <= r_ucnt[N_2-1:0];
            end else begin
                r_ucnt <= '0;
            end
        end
    end

    assign fft_load  = (r_state == S_LOAD);
    assign fft_start = (r_state == S_START);
    assign busy      = (r_state != S_FILL);
    assign fft_rd    = fft_load ? r_buf[r_rptr] : '0;

`ifdef FFT_SEQ_OVERRUN_CNT_EN
    logic [7:0] r_ovr;
    logic       w_drop;

    assign w_drop = sample_valid && !w_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovr <= '0;
        end else if (w_drop && (r_ovr != 8'hFF)) begin
            r_ovr <= r_ovr + 1'b1;
        end
    end

    assign overrun = r_ovr;
`else
    assign overrun = 8'd0;
`endif

endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: randomized and directed stimulus against a frame-level reference model.
// Honours FFT_SEQ_OVERRUN_CNT_EN for the expected overrun count.
module tb_fft_sequencer;

    localparam int W  = 16;
    localparam int N2 = 5;
    localparam int N  = 32;
`ifdef FFT_SEQ_OVERRUN_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           run = 1'b0;
    logic           sample_valid = 1'b0;
    logic [W-1:0]   sample = '0;
    logic           fft_done = 1'b0;
    logic [2*W-1:0] fft_wd = '0;
    logic           fft_load;
    logic [W-1:0]   fft_rd;
    logic           fft_start;
    logic           out_valid;
    logic [2*W-1:0] out_data;
    logic [N2-1:0]  out_idx;
    logic           out_last;
    logic           busy;
    logic [7:0]     overrun;

    fft_sequencer #(.width(W), .N_2(N2)) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .sample_valid(sample_valid),
        .sample(sample),
        .fft_load(fft_load),
        .fft_rd(fft_rd),
        .fft_start(fft_start),
        .fft_done(fft_done),
        .fft_wd(fft_wd),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_idx(out_idx),
        .out_last(out_last),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, a, e, cyc);
        end
    endtask

    // Reference model: phase 0 fill, 1 load, 2 start, 3 wait, 4 unload.
    int             m_phase = 0;
    int             m_cnt = 0;
    int             m_li = 0;
    int             m_ui = 0;
    int             m_ovr = 0;
    logic [W-1:0]   m_frame [N];
    logic           m_ov = 1'b0;
    logic           m_ol = 1'b0;
    logic [2*W-1:0] m_od = '0;
    int             m_oi = 0;

    task automatic model_reset();
        m_phase = 0;
        m_cnt = 0;
        m_li = 0;
        m_ui = 0;
        m_ovr = 0;
        m_ov = 1'b0;
        m_ol = 1'b0;
        m_od = '0;
        m_oi = 0;
    endtask

    task automatic model_step();
        int  old;
        bit  took;
        bit  keep;
        old  = m_phase;
        took = 1'b0;
        keep = run || (m_phase == 4);
        m_ov = 1'b0;
        m_ol = 1'b0;
        case (m_phase)
            0: if (run && sample_valid) begin
                m_frame[m_cnt] = sample;
                m_cnt++;
                took = 1'b1;
                if (m_cnt == N) begin
                    m_phase = 1;
                    m_li = 0;
                end
            end
            1: begin
                m_li++;
                if (m_li == N) m_phase = 2;
            end
            2: m_phase = 3;
            3: if (fft_done && run) begin
                m_od = fft_wd;
                m_oi = 0;
                m_ov = 1'b1;
                m_ui = 1;
                m_phase = 4;
            end
            default: if (fft_done) begin
                m_od = fft_wd;
                m_oi = m_ui;
                m_ov = 1'b1;
                m_ol = (m_ui == N - 1);
                m_ui++;
                if (m_ui == N) m_phase = 0;
            end else begin
                m_phase = 0;
            end
        endcase
        if (!keep) m_phase = 0;
        if (m_phase == 0 && (old != 0 || !run)) m_cnt = 0;
        if (OVR_EN && sample_valid && !took && m_ovr < 255) m_ovr++;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_load", fft_load, 0);
            chk("rst_start", fft_start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_last", out_last, 0);
            chk("rst_data", out_data, 0);
            chk("rst_idx", out_idx, 0);
            chk("rst_rd", fft_rd, 0);
            chk("rst_ovr", overrun, 0);
        end else begin
            chk("busy", busy, m_phase != 0);
            chk("load", fft_load, m_phase == 1);
            chk("start", fft_start, m_phase == 2);
            chk("load_start_excl", fft_load && fft_start, 0);
            if (m_phase == 1) chk("rd", fft_rd, m_frame[m_li]);
            chk("valid", out_valid, m_ov);
            chk("last", out_last, m_ol);
            if (m_ov) begin
                chk("data", out_data, m_od);
                chk("idx", out_idx, m_oi);
            end
            chk("overrun", overrun, m_ovr);
        end
    end

    int n_load = 0;
    int n_start = 0;
    int n_valid = 0;
    int n_last = 0;

    always @(negedge clk) begin
        if (reset) begin
            n_load  += int'(fft_load);
            n_start += int'(fft_start);
            n_valid += int'(out_valid);
            n_last  += int'(out_last);
        end
    end

    int lastw = 0;
    int st_cyc = 0;

    task automatic send(input int n, input int gap, input bit seq,
                        input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample = seq ? W'(base + i) : W'($urandom);
            lastw = cyc;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                sample_valid = 1'b0;
            end
        end
        if (gap == 0) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            fft_done = 1'b0;
        end
    endtask

    task automatic wait_start();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (fft_start) begin
                seen = 1'b1;
                st_cyc = cyc;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL start_timeout: no fft_start in 200 cycles");
        end
    endtask

    task automatic stream(input int n, input bit pat);
        logic [W-1:0] kk;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            kk = W'(k);
            fft_done = 1'b1;
            fft_wd = pat ? {kk, ~kk} : (2*W)'($urandom);
        end
        @(negedge clk);
        fft_done = 1'b0;
    endtask

    int s_load, s_start, s_valid, s_last;

    task automatic snap();
        s_load = n_load;
        s_start = n_start;
        s_valid = n_valid;
        s_last = n_last;
    endtask

    initial begin
        int burst;
        int cnt;
        // Reset state and first frame: 0..31 every 4th cycle.
        idle(3);
        @(negedge clk);
        reset = 1'b1;
        run = 1'b1;
        snap();
        send(N, 3, 1'b1, 0);
        wait_start();
        chk("latency", st_cyc - lastw, N + 1);
        idle(2);
        chk("n_load", n_load - s_load, 32);
        chk("n_start", n_start - s_start, 1);
        stream(N, 1'b1);
        idle(3);
        chk("n_valid_full", n_valid - s_valid, 32);
        chk("n_last_full", n_last - s_last, 1);
        chk("busy_after", busy, 0);

        // Sample flood while waiting on the core.
        send(N, $urandom_range(1, 3), 1'b0, 0);
        wait_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample = W'($urandom);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        chk("overrun_sat", overrun, OVR_EN ? 255 : 0);
        idle(2);
        stream(N, 1'b0);
        idle(3);

        // Result stream cut short after 10 words.
        snap();
        send(N, 1, 1'b0, 0);
        wait_start();
        idle(3);
        stream(10, 1'b0);
        idle(3);
        chk("n_valid_abort", n_valid - s_valid, 10);
        chk("n_last_abort", n_last - s_last, 0);
        chk("busy_abort", busy, 0);
        snap();
        send(N, 0, 1'b1, 100);
        wait_start();
        stream(N, 1'b1);
        idle(3);
        chk("n_last_next", n_last - s_last, 1);

        // Reset while presenting word 12 of the load.
        send(N, 1, 1'b0, 0);
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 13; i++) begin
            @(negedge clk);
            if (fft_load) cnt++;
        end
        chk("load_reach_12", cnt, 13);
        #1 reset = 1'b0;
        #1;
        chk("async_load", fft_load, 0);
        chk("async_rd", fft_rd, 0);
        chk("async_busy", busy, 0);
        chk("async_start", fft_start, 0);
        chk("async_valid", out_valid, 0);
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        snap();
        send(N - 1, 1, 1'b0, 0);
        idle(40);
        chk("no_load_31", n_load - s_load, 0);
        send(1, 1, 1'b0, 0);
        wait_start();
        stream(N, 1'b1);
        idle(3);

        // run dropped after 20 samples restarts the frame.
        send(20, 1, 1'b1, 500);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        snap();
        send(12, 1, 1'b1, 700);
        idle(40);
        chk("no_load_run", n_load - s_load, 0);
        send(20, 1, 1'b1, 712);
        wait_start();
        stream(N, 1'b0);
        idle(3);
        chk("n_load_run", n_load - s_load, 32);

        // Fully random traffic.
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            run = ($urandom_range(0, 299) != 0);
            sample_valid = ($urandom_range(0, 2) == 0);
            sample = W'($urandom);
            if (burst > 0) begin
                fft_done = 1'b1;
                fft_wd = (2*W)'($urandom);
                burst--;
            end else begin
                fft_done = 1'b0;
                if ($urandom_range(0, 29) == 0)
                    burst = $urandom_range(1, 40);
            end
        end
        run = 1'b1;
        idle(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
